// File: rtl/aes_bus_pkg.sv
// aes_bus_pkg: state encoding and bus constants shared by the AES Avalon-MM master and its users.
package aes_bus_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD} state_e;
  localparam logic [3:0] AES_WR_ADDR = 4'h0;
  localparam logic [3:0] AES_RD_ADDR = 4'h4;
  localparam int AES_WORDS = 4;
  localparam int AES_BLK_W = 128;
endpackage

// File: rtl/aes_avm_block_master.sv
// aes_avm_block_master: writes 128-bit plaintext blocks to the AES slave as four words and
// reads ciphertext back in order, with waitrequest stalls and inflight-bounded backpressure.
module aes_avm_block_master
  import aes_bus_pkg::*;
#(
  parameter int          MAX_INFLIGHT = 8,
  parameter logic [3:0]  WR_ADDR      = AES_WR_ADDR,
  parameter logic [3:0]  RD_ADDR      = AES_RD_ADDR,
  parameter int          CNT_W        = 16
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic                                 pt_valid,
  output logic                                 pt_ready,
  input  logic [AES_BLK_W-1:0]                 pt_data,
  output logic                                 ct_valid,
  input  logic                                 ct_ready,
  output logic [AES_BLK_W-1:0]                 ct_data,
  output logic                                 avm_chipselect,
  output logic [3:0]                           avm_address,
  output logic                                 avm_write,
  output logic [31:0]                          avm_writedata,
  output logic                                 avm_read,
  input  logic [31:0]                          avm_readdata,
  input  logic                                 avm_waitrequest,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
  output logic [CNT_W-1:0]                     blk_done
);
  localparam int IW = $clog2(MAX_INFLIGHT+1);
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [AES_BLK_W-1:0] buf_q, buf_d, ct_data_q, ct_data_d;
  logic cs_q, cs_d, wr_q, wr_d, rd_q, rd_d, pt_ready_q, pt_ready_d, ct_valid_q, ct_valid_d;
  logic [3:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] blk_done_q, blk_done_d;
  logic last, rd_go;
  assign last  = idx_q == 2'(AES_WORDS-1);
  assign rd_go = inflight_q != '0 && !ct_valid_q && (inflight_q == IW'(MAX_INFLIGHT) || !pt_valid);
  // buf_q is the outgoing word shifter in WR and the incoming one in RD; the two never overlap
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    cs_d       = cs_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ct_data_d  = ct_data_q;
    inflight_d = inflight_q;
    ct_valid_d = ct_valid_q && !ct_ready;
    blk_done_d = blk_done_q + CNT_W'(ct_valid_q && ct_ready);
    case (state_q)
      IDLE:
        if (pt_valid && pt_ready_q) begin
          state_d = WR;
          idx_d   = '0;
          buf_d   = pt_data << 32;
          wdata_d = pt_data[127:96];
          cs_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = WR_ADDR;
        end else if (rd_go) begin
          state_d = RD;
          idx_d   = '0;
          cs_d    = 1'b1;
          rd_d    = 1'b1;
          addr_d  = RD_ADDR;
        end
      WR:
        if (!avm_waitrequest) begin
          idx_d   = idx_q + 2'd1;
          wdata_d = buf_q[127:96];
          buf_d   = buf_q << 32;
          if (last) begin
            state_d    = IDLE;
            cs_d       = 1'b0;
            wr_d       = 1'b0;
            inflight_d = inflight_q + IW'(1);
          end
        end
      RD:
        if (!avm_waitrequest) begin
          idx_d = idx_q + 2'd1;
          buf_d = {buf_q[95:0], avm_readdata};
          if (last) begin
            state_d    = IDLE;
            cs_d       = 1'b0;
            rd_d       = 1'b0;
            ct_data_d  = {buf_q[95:0], avm_readdata};
            ct_valid_d = 1'b1;
            inflight_d = inflight_q - IW'(1);
          end
        end
      default: state_d = IDLE;
    endcase
    pt_ready_d = state_d == IDLE && inflight_d < IW'(MAX_INFLIGHT);
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      cs_q       <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ct_data_q  <= '0;
      ct_valid_q <= 1'b0;
      pt_ready_q <= 1'b0;
      inflight_q <= '0;
      blk_done_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      cs_q       <= cs_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ct_data_q  <= ct_data_d;
      ct_valid_q <= ct_valid_d;
      pt_ready_q <= pt_ready_d;
      inflight_q <= inflight_d;
      blk_done_q <= blk_done_d;
    end
  end
  assign pt_ready       = pt_ready_q;
  assign ct_valid       = ct_valid_q;
  assign ct_data        = ct_data_q;
  assign avm_chipselect = cs_q;
  assign avm_address    = addr_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_read       = rd_q;
  assign inflight       = inflight_q;
  assign blk_done       = blk_done_q;
endmodule

// File: tb/tb_aes_avm_block_master.sv
// tb_aes_avm_block_master: FIFO AES slave model, stream source/sink and a ciphertext scoreboard.
module tb_aes_avm_block_master;
  import aes_bus_pkg::*;
  localparam int MAXI = 8;
  localparam logic [127:0] KEY = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  localparam logic [127:0] PT1 = 128'hffeeddcc_bbaa9988_77665544_33221100;
  localparam logic [127:0] PT2 = 128'hf47237c1_5a83b6e0_9d3f11a4_c2e86732;
  logic clock = 0, resetn = 1;
  logic pt_valid, pt_ready, ct_valid, ct_ready;
  logic [127:0] pt_data, ct_data;
  logic avm_chipselect, avm_write, avm_read, avm_waitrequest;
  logic [3:0] avm_address;
  logic [31:0] avm_writedata, avm_readdata;
  logic [3:0] inflight;
  logic [15:0] blk_done;
  int total = 0, bad = 0;
  logic [127:0] src[$], exp_q[$], sfifo[$];
  logic [31:0] wlog[$];
  int wcyc[$];
  bit ops[$];
  bit src_en = 1, sink_en = 1;
  int delivered = 0, viol = 0, wcnt = 0, rcnt = 0, max_inf = 0, watch_cnt = 0, stall_left = 0, cyc = 0;
  logic [31:0] watch = '0;
  logic [127:0] cur = '0;

  aes_avm_block_master #(.MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .resetn(resetn),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data),
    .avm_chipselect(avm_chipselect), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .inflight(inflight), .blk_done(blk_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [127:0] enc(input logic [127:0] p);
    return p ^ KEY;
  endfunction

  function automatic int count_ops(input bit w);
    int n = 0;
    foreach (ops[i]) if (ops[i] == w) n++;
    return n;
  endfunction

  // Slave: decides waitrequest/readdata at the falling edge for the next rising edge
  initial begin
    logic [127:0] blkw;
    avm_waitrequest = 0;
    avm_readdata = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        wcnt = 0; rcnt = 0; sfifo.delete(); avm_waitrequest = 0;
      end else begin
        if (int'(inflight) > max_inf) max_inf = int'(inflight);
        if (pt_ready && inflight == 4'(MAXI)) viol++;
        if (avm_read && inflight == 4'd0) viol++;
        if (avm_write && avm_read) viol++;
        if ((avm_write || avm_read) && !avm_chipselect) viol++;
        avm_waitrequest = 0;
        if (avm_chipselect && avm_write) begin
          if (avm_address != AES_WR_ADDR || rcnt % 4 != 0) viol++;
          if (avm_writedata == watch) watch_cnt++;
          if (stall_left > 0 && wcnt % 4 == 2) begin
            avm_waitrequest = 1;
            stall_left--;
          end else begin
            wlog.push_back(avm_writedata);
            wcyc.push_back(cyc);
            ops.push_back(1'b1);
            cur = {cur[95:0], avm_writedata};
            wcnt++;
            if (wcnt % 4 == 0) sfifo.push_back(enc(cur));
          end
        end else if (avm_chipselect && avm_read) begin
          if (avm_address != AES_RD_ADDR || wcnt % 4 != 0 || sfifo.size() == 0) viol++;
          else begin
            blkw = sfifo[0];
            avm_readdata = blkw[127-32*(rcnt%4) -: 32];
            ops.push_back(1'b0);
            rcnt++;
            if (rcnt % 4 == 0) void'(sfifo.pop_front());
          end
        end
      end
    end
  end

  initial begin
    pt_valid = 0;
    pt_data = '0;
    forever begin
      @(negedge clock);
      pt_valid = resetn && src_en && src.size() > 0;
      pt_data = pt_valid ? src[0] : '0;
      if (pt_valid && pt_ready) exp_q.push_back(enc(src.pop_front()));
    end
  end

  initial begin
    logic [127:0] e;
    ct_ready = 0;
    forever begin
      @(negedge clock);
      ct_ready = sink_en;
      if (resetn && ct_valid && ct_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ct_order: got block %h, expected none", ct_data);
        end else begin
          e = exp_q.pop_front();
          if (ct_data !== e) begin
            bad++;
            $display("FAIL ct_data: got %h expected %h", ct_data, e);
          end
        end
        delivered++;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_del(input int target, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (delivered >= target) begin
        ok = 1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    #1 resetn = 0;
    #1;
    total++;
    if ({avm_chipselect, avm_address, avm_write, avm_writedata, avm_read} !== '0) begin
      bad++;
      $display("FAIL reset_bus: got cs=%b addr=%h wr=%b wd=%h rd=%b expected all 0",
               avm_chipselect, avm_address, avm_write, avm_writedata, avm_read);
    end
    total++;
    if ({pt_ready, ct_valid, ct_data, inflight, blk_done} !== '0) begin
      bad++;
      $display("FAIL reset_stream: got pt_ready=%b ct_valid=%b ct_data=%h inflight=%0d blk_done=%0d expected all 0",
               pt_ready, ct_valid, ct_data, inflight, blk_done);
    end
    repeat (3) tick();
    resetn = 1;
    tick();
    total++;
    if (pt_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b expected 1", pt_ready);
    end
  endtask

  task automatic test_single();
    logic [31:0] ew[4] = '{32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
    int r0 = rcnt, d0 = delivered;
    logic [15:0] b0 = blk_done;
    bit ok;
    wlog.delete(); wcyc.delete(); max_inf = 0;
    src.push_back(PT1);
    wait_del(d0 + 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout: got %0d blocks expected %0d", delivered - d0, 1); end
    total++;
    if (wlog.size() != 4) begin bad++; $display("FAIL single_nwrites: got %0d expected 4", wlog.size()); end
    else for (int i = 0; i < 4; i++) begin
      total++;
      if (wlog[i] !== ew[i]) begin bad++; $display("FAIL single_word%0d: got %h expected %h", i, wlog[i], ew[i]); end
    end
    total++;
    if (wcyc.size() == 4 && wcyc[3] - wcyc[0] != 3) begin
      bad++; $display("FAIL single_consecutive: got span %0d expected 3", wcyc[3] - wcyc[0]);
    end
    total++;
    if (max_inf != 1) begin bad++; $display("FAIL single_inflight: got %0d expected 1", max_inf); end
    total++;
    if (rcnt - r0 != 4) begin bad++; $display("FAIL single_nreads: got %0d expected 4", rcnt - r0); end
    total++;
    if (ct_data !== (PT1 ^ KEY)) begin bad++; $display("FAIL single_ct: got %h expected %h", ct_data, PT1 ^ KEY); end
    total++;
    if (blk_done !== b0 + 16'd1) begin bad++; $display("FAIL single_blk_done: got %0d expected %0d", blk_done, b0 + 16'd1); end
  endtask

  task automatic test_waitrequest();
    int d0 = delivered, n = 0;
    bit ok;
    wlog.delete(); watch = 32'h77665544; watch_cnt = 0; stall_left = 3;
    src.push_back(PT1);
    wait_del(d0 + 1, ok);
    foreach (wlog[i]) if (wlog[i] == watch) n++;
    total++;
    if (!ok) begin bad++; $display("FAIL stall_timeout: got %0d blocks expected 1", delivered - d0); end
    total++;
    if (watch_cnt != 4) begin bad++; $display("FAIL stall_hold: got %0d cycles expected 4", watch_cnt); end
    total++;
    if (n != 1 || wlog.size() != 4) begin
      bad++; $display("FAIL stall_accept: got %0d accepts of word2, %0d writes; expected 1 and 4", n, wlog.size());
    end
    watch = '0;
  endtask

  task automatic test_fill();
    int d0 = delivered, wfirst = 0;
    logic [15:0] b0 = blk_done;
    bit ok;
    ops.delete(); max_inf = 0;
    for (int i = 0; i < 8; i++) src.push_back(i % 2 ? PT2 : PT1);
    wait_del(d0 + 8, ok);
    foreach (ops[i]) begin
      if (!ops[i]) break;
      wfirst++;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL fill_timeout: got %0d blocks expected 8", delivered - d0); end
    total++;
    if (wfirst != 32) begin bad++; $display("FAIL fill_writes_first: got %0d expected 32", wfirst); end
    total++;
    if (max_inf != MAXI) begin bad++; $display("FAIL fill_inflight_peak: got %0d expected %0d", max_inf, MAXI); end
    total++;
    if (count_ops(1'b0) != 32) begin bad++; $display("FAIL fill_reads: got %0d expected 32", count_ops(1'b0)); end
    total++;
    if (16'(blk_done - b0) !== 16'd8) begin bad++; $display("FAIL fill_blk_done: got %0d expected 8", 16'(blk_done - b0)); end
    total++;
    if (viol != 0) begin bad++; $display("FAIL fill_protocol: got %0d violations expected 0", viol); end
  endtask

  task automatic test_backpressure();
    int d0 = delivered;
    logic [15:0] b0 = blk_done;
    bit ok, found = 0;
    ops.delete(); sink_en = 0;
    src.push_back(PT1); src.push_back(PT2); src.push_back(PT1);
    for (int i = 0; i < 500; i++) begin
      tick();
      if (ct_valid && inflight == 4'd2) begin found = 1; break; end
    end
    repeat (20) tick();
    total++;
    if (!found) begin bad++; $display("FAIL bp_timeout: got inflight=%0d ct_valid=%b expected 2 and 1", inflight, ct_valid); end
    total++;
    if (count_ops(1'b0) != 4 || inflight !== 4'd2 || avm_chipselect !== 1'b0) begin
      bad++; $display("FAIL bp_stall: got reads=%0d inflight=%0d cs=%b expected 4, 2, 0", count_ops(1'b0), inflight, avm_chipselect);
    end
    sink_en = 1;
    wait_del(d0 + 3, ok);
    total++;
    if (!ok || count_ops(1'b0) != 12 || inflight !== 4'd0) begin
      bad++; $display("FAIL bp_resume: got ok=%b reads=%0d inflight=%0d expected 1, 12, 0", ok, count_ops(1'b0), inflight);
    end
    total++;
    if (16'(blk_done - b0) !== 16'd3) begin bad++; $display("FAIL bp_blk_done: got %0d expected 3", 16'(blk_done - b0)); end
  endtask

  task automatic test_mixed();
    int d0 = delivered;
    bit ok, found = 0, order_ok = 1;
    ops.delete(); sink_en = 0;
    src.push_back(PT2); src.push_back(PT1); src.push_back(PT2);
    for (int i = 0; i < 500; i++) begin
      tick();
      if (ct_valid && inflight == 4'd2) begin found = 1; break; end
    end
    src.push_back(PT1);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (inflight == 4'd3) break;
    end
    repeat (5) tick();
    if (ops.size() != 20) order_ok = 0;
    else foreach (ops[i]) if (ops[i] != (i < 12 || i >= 16)) order_ok = 0;
    total++;
    if (!found || !order_ok) begin
      bad++; $display("FAIL mixed_order: got found=%b ops=%0d writes=%0d expected 1, 20, 16", found, ops.size(), count_ops(1'b1));
    end
    total++;
    if (ct_valid !== 1'b1 || inflight !== 4'd3) begin
      bad++; $display("FAIL mixed_hold: got ct_valid=%b inflight=%0d expected 1, 3", ct_valid, inflight);
    end
    sink_en = 1;
    wait_del(d0 + 4, ok);
    total++;
    if (!ok || inflight !== 4'd0 || viol != 0) begin
      bad++; $display("FAIL mixed_drain: got ok=%b inflight=%0d viol=%0d expected 1, 0, 0", ok, inflight, viol);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    bit ok, found = 0;
    wlog.delete();
    src.push_back(PT2);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (wlog.size() >= 2) begin found = 1; break; end
    end
    @(posedge clock);
    #2 resetn = 0;
    #1;
    total++;
    if (!found || {avm_chipselect, avm_write, avm_writedata, avm_address, avm_read, pt_ready, inflight, blk_done} !== '0) begin
      bad++; $display("FAIL midreset_outputs: got found=%b cs=%b wr=%b wd=%h addr=%h inflight=%0d blk_done=%0d expected 1 then all 0",
                      found, avm_chipselect, avm_write, avm_writedata, avm_address, inflight, blk_done);
    end
    src.delete(); exp_q.delete();
    repeat (2) tick();
    resetn = 1;
    tick();
    d0 = delivered;
    src.push_back(PT1);
    wait_del(d0 + 1, ok);
    total++;
    if (!ok || blk_done !== 16'd1 || ct_data !== (PT1 ^ KEY)) begin
      bad++; $display("FAIL midreset_recover: got ok=%b blk_done=%0d ct=%h expected 1, 1, %h", ok, blk_done, ct_data, PT1 ^ KEY);
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL protocol: got %0d violations expected 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_waitrequest();
    test_fill();
    test_backpressure();
    test_mixed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
